// File: rtl/osd_bcd_digit_writer.sv
// osd_bcd_digit_writer
//   Turns a packed BCD value into OSD character codes, most significant digit
//   first. Each character goes out as one write on a valid/ready RAM port.
//   A one-deep pending slot absorbs an i_DV that arrives while a string is
//   still being written. A further i_DV while the slot is full is dropped and
//   reported on o_Overrun.
//
// Build option: define OSD_BCD_LEADING_BLANK_EN to blank leading zeros. The
//   least significant digit is always written as a numeral. When the option
//   is undefined, every digit is written zero-padded. The number of writes
//   and their timing are the same in both builds.
//
// Ports
//   i_Clock, i_Reset_n      clock; asynchronous active-low reset
//   i_BCD, i_DV             packed BCD (digit 0 in [3:0]) and its strobe
//   i_Base_Addr             RAM address of the leftmost character
//   o_Wr_En/Addr/Data       write request; held while i_Wr_Ready is low
//   i_Wr_Ready              write accepted on an edge with o_Wr_En
//   o_Busy                  a string is in progress
//   o_Done                  one-cycle pulse after the last accept
//   o_Overrun               one-cycle pulse when an i_DV is discarded
module osd_bcd_digit_writer #(
    parameter int         DECIMAL_DIGITS = 5,
    parameter int         ADDR_WIDTH     = 10,
    parameter logic [7:0] CHAR_ZERO      = 8'h30,
    parameter logic [7:0] CHAR_BLANK     = 8'h20,
    parameter logic [7:0] CHAR_BAD       = 8'h3F
) (
    input  logic                        i_Clock,
    input  logic                        i_Reset_n,
    input  logic [DECIMAL_DIGITS*4-1:0] i_BCD,
    input  logic                        i_DV,
    input  logic [ADDR_WIDTH-1:0]       i_Base_Addr,
    output logic                        o_Wr_En,
    output logic [ADDR_WIDTH-1:0]       o_Wr_Addr,
    output logic [7:0]                  o_Wr_Data,
    input  logic                        i_Wr_Ready,
    output logic                        o_Busy,
    output logic                        o_Done,
    output logic                        o_Overrun
);
    localparam int BW = DECIMAL_DIGITS * 4;
    localparam int IW = $clog2(DECIMAL_DIGITS + 1);

    typedef enum logic [1:0] {IDLE, EMIT, DONE} state_t;

    state_t                state;
    logic [BW-1:0]         bcd_q;      // digits not yet presented, MS digit at the top
    logic [IW-1:0]         idx;        // digits left after the one on the port
    logic                  slot_full;
    logic [BW-1:0]         slot_bcd;
    logic [ADDR_WIDTH-1:0] slot_addr;

    logic                  do_load;
    logic [BW-1:0]         ld_bcd;
    logic [ADDR_WIDTH-1:0] ld_addr;
    logic [3:0]            ld_nib;
    logic [3:0]            nx_nib;
    logic [7:0]            ld_char;
    logic [7:0]            nx_char;

    // A string starts from IDLE on i_DV. It also starts from DONE, out of the
    // slot if the slot is full, or straight from an i_DV that arrives in that
    // cycle.
    assign do_load = (state == IDLE && i_DV) || (state == DONE && (slot_full || i_DV));
    assign ld_bcd  = (state == DONE && slot_full) ? slot_bcd  : i_BCD;
    assign ld_addr = (state == DONE && slot_full) ? slot_addr : i_Base_Addr;
    assign ld_nib  = ld_bcd[BW-1 -: 4];
    assign nx_nib  = bcd_q[BW-1 -: 4];

`ifdef OSD_BCD_LEADING_BLANK_EN
    logic blank_q;  // every digit presented so far was zero

    function automatic logic [7:0] char_of(input logic [3:0] nib, input logic blank,
                                           input logic last);
        if (nib > 4'd9)                       return CHAR_BAD;
        if (blank && nib == 4'd0 && !last)    return CHAR_BLANK;
        return CHAR_ZERO + {4'd0, nib};
    endfunction

    assign ld_char = char_of(ld_nib, 1'b1, DECIMAL_DIGITS == 1);
    assign nx_char = char_of(nx_nib, blank_q, idx == IW'(1));

    always_ff @(posedge i_Clock or negedge i_Reset_n) begin
        if (!i_Reset_n)
            blank_q <= 1'b0;
        else if (do_load)
            blank_q <= (ld_nib == 4'd0);
        // Any nonzero nibble, including an illegal one, ends the blanking.
        else if (state == EMIT && i_Wr_Ready && idx != '0)
            blank_q <= blank_q && (nx_nib == 4'd0);
    end
`else
    function automatic logic [7:0] char_of(input logic [3:0] nib);
        if (nib > 4'd9) return CHAR_BAD;
        return CHAR_ZERO + {4'd0, nib};
    endfunction

    assign ld_char = char_of(ld_nib);
    assign nx_char = char_of(nx_nib);
`endif

    always_ff @(posedge i_Clock or negedge i_Reset_n) begin
        if (!i_Reset_n) begin
            state     <= IDLE;
            bcd_q     <= '0;
            idx       <= '0;
            slot_full <= 1'b0;
            slot_bcd  <= '0;
            slot_addr <= '0;
            o_Wr_En   <= 1'b0;
            o_Wr_Addr <= '0;
            o_Wr_Data <= '0;
            o_Busy    <= 1'b0;
            o_Done    <= 1'b0;
            o_Overrun <= 1'b0;
        end else begin
            o_Done    <= 1'b0;
            o_Overrun <= 1'b0;

            // While a string is in progress, i_DV goes to the slot. If the
            // slot is already full, the new i_DV is dropped.
            if (i_DV && state != IDLE) begin
                if (slot_full) begin
                    o_Overrun <= 1'b1;
                end else if (state == EMIT) begin
                    slot_full <= 1'b1;
                    slot_bcd  <= i_BCD;
                    slot_addr <= i_Base_Addr;
                end
            end

            if (do_load) begin
                state     <= EMIT;
                o_Busy    <= 1'b1;
                o_Wr_En   <= 1'b1;
                o_Wr_Addr <= ld_addr;
                o_Wr_Data <= ld_char;
                bcd_q     <= ld_bcd << 4;
                idx       <= IW'(DECIMAL_DIGITS - 1);
                if (state == DONE && slot_full)
                    slot_full <= 1'b0;
            end else if (state == DONE) begin
                state  <= IDLE;
                o_Busy <= 1'b0;
            end else if (state == EMIT && i_Wr_Ready) begin
                if (idx == '0) begin
                    state   <= DONE;
                    o_Wr_En <= 1'b0;
                    o_Done  <= 1'b1;
                end else begin
                    // No bubble: the next character is on the port right after the accept.
                    o_Wr_Addr <= o_Wr_Addr + ADDR_WIDTH'(1);
                    o_Wr_Data <= nx_char;
                    bcd_q     <= bcd_q << 4;
                    idx       <= idx - IW'(1);
                end
            end
        end
    end
endmodule

// File: tb/tb_osd_bcd_digit_writer.sv
module tb_osd_bcd_digit_writer;
    logic        clk = 1'b0;
    logic        rst_n;
    logic [19:0] bcd;
    logic        dv;
    logic [9:0]  base;
    logic        wr_en;
    logic [9:0]  wr_addr;
    logic [7:0]  wr_data;
    logic        ready;
    logic        busy, done, ovr;

    int n_chk = 0, n_fail = 0;
    int acc_cnt = 0, done_cnt = 0, ovr_cnt = 0;
    logic [17:0] sb[$];   // expected {addr, char}

    osd_bcd_digit_writer #(.DECIMAL_DIGITS(5), .ADDR_WIDTH(10)) dut (
        .i_Clock(clk), .i_Reset_n(rst_n), .i_BCD(bcd), .i_DV(dv),
        .i_Base_Addr(base), .o_Wr_En(wr_en), .o_Wr_Addr(wr_addr),
        .o_Wr_Data(wr_data), .i_Wr_Ready(ready), .o_Busy(busy),
        .o_Done(done), .o_Overrun(ovr));

    always #5 clk = ~clk;

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_chk++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Reference character stream: MS digit first; A-F -> 3F; leading zeros
    // are blanked in the blanking build, except for the last digit.
    task automatic push_exp(input logic [19:0] b, input logic [9:0] a);
        logic       seen;
        logic [3:0] nib;
        logic [7:0] c;
        logic [9:0] ad;
        seen = 1'b0;
        for (int k = 0; k < 5; k++) begin
            nib = b[(4-k)*4 +: 4];
            if (nib > 4'd9) c = 8'h3F;
`ifdef OSD_BCD_LEADING_BLANK_EN
            else if (!seen && nib == 4'd0 && k != 4) c = 8'h20;
`endif
            else c = 8'h30 + {4'd0, nib};
            if (nib != 4'd0) seen = 1'b1;
            ad = a + 10'(k);
            sb.push_back({ad, c});
        end
    endtask

    // Scoreboard: every accepted write is checked against the queue head.
    always @(negedge clk) begin
        if (rst_n) begin
            if (done) done_cnt++;
            if (ovr)  ovr_cnt++;
            if (wr_en && ready) begin
                acc_cnt++;
                if (sb.size() == 0) begin
                    n_chk++;
                    n_fail++;
                    $error("FAIL unexpected_write observed=%0h expected=none", {wr_addr, wr_data});
                end else begin
                    chk("wr_addr_data", {14'd0, wr_addr, wr_data}, {14'd0, sb.pop_front()});
                end
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic send(input logic [19:0] b, input logic [9:0] a, input bit exp);
        bcd = b; base = a; dv = 1'b1;
        if (exp) push_exp(b, a);
        tick();
        dv = 1'b0;
    endtask

    task automatic wait_done(input string tag);
        int t;
        t = 0;
        while (!done && t < 100) begin tick(); t++; end
        chk(tag, done, 1);
    endtask

    task automatic run_str(input logic [19:0] b, input logic [9:0] a, input string tag);
        send(b, a, 1);
        wait_done(tag);
        tick();
        chk({tag, "_sb_empty"}, sb.size(), 0);
    endtask

    initial begin
        logic [7:0]  pat;
        logic [17:0] held;
        int a0, d0, o0;
        rst_n = 1'b0; dv = 1'b0; ready = 1'b1; bcd = '0; base = '0;
        tick(); tick();
        chk("rst_wr_en", wr_en, 0);
        chk("rst_busy", busy, 0);
        chk("rst_done", done, 0);
        chk("rst_ovr", ovr, 0);
        chk("rst_addr_data", {wr_addr, wr_data}, 0);
        rst_n = 1'b1;
        tick();

        // 1: basic string, latency and o_Done timing
        send(20'h12345, 10'h010, 1);
        chk("t1_busy", busy, 1);
        chk("t1_first_wr", {wr_en, wr_addr, wr_data}, {1'b1, 10'h010, 8'h31});
        repeat (4) tick();
        chk("t1_done_early", done, 0);
        tick();
        chk("t1_done", done, 1);
        chk("t1_busy_done", busy, 1);
        chk("t1_wr_en_off", wr_en, 0);
        tick();
        chk("t1_done_pulse", done, 0);
        chk("t1_idle", busy, 0);
        chk("t1_accepts", acc_cnt, 5);
        chk("t1_sb_empty", sb.size(), 0);

        // 2/3: blanking / padding and illegal nibbles
        run_str(20'h00042, 10'h020, "t2_42");
        run_str(20'h00000, 10'h030, "t2_zero");
        run_str(20'h1A345, 10'h040, "t3_bad");
        run_str(20'h0F000, 10'h050, "t3_bad_lead");

        // 4: address wrap with a stalled port
        a0 = acc_cnt;
        pat = 8'b11101001;   // cycle 0 first: 1,0,0,1,0,1,1,1
        send(20'h98765, 10'h3FE, 1);
        held = '0;
        for (int i = 0; i < 8; i++) begin
            if (i > 0 && !pat[i-1]) chk("t4_stable", {wr_en, wr_addr, wr_data}, {1'b1, held});
            held = {wr_addr, wr_data};
            ready = pat[i];
            tick();
        end
        chk("t4_accepts", acc_cnt - a0, 5);
        chk("t4_done", done, 1);
        ready = 1'b1;
        tick();
        chk("t4_idle", busy, 0);
        chk("t4_sb_empty", sb.size(), 0);
        chk("no_ovr_so_far", ovr_cnt, 0);

        // 5: A busy, B to slot, C dropped
        d0 = done_cnt; o0 = ovr_cnt;
        send(20'h11111, 10'h100, 1);
        tick();
        send(20'h22222, 10'h200, 1);
        tick();
        send(20'h33333, 10'h300, 0);
        wait_done("t5_done_a");
        tick();
        chk("t5_b_back_to_back", {wr_en, wr_addr}, {1'b1, 10'h200});
        wait_done("t5_done_b");
        tick();
        chk("t5_done_cnt", done_cnt - d0, 2);
        chk("t5_ovr_cnt", ovr_cnt - o0, 1);
        chk("t5_idle", busy, 0);
        chk("t5_sb_empty", sb.size(), 0);

        // 6: reset mid-string with the slot full
        a0 = acc_cnt;
        send(20'h54321, 10'h050, 1);
        send(20'h67890, 10'h060, 0);
        tick();
        chk("t6_two_accepts", acc_cnt - a0, 2);
        rst_n = 1'b0;
        #1;
        chk("t6_rst_outputs", {wr_en, busy, done, ovr, wr_addr, wr_data}, 0);
        sb.delete();
        tick(); tick();
        rst_n = 1'b1;
        repeat (12) tick();
        chk("t6_no_writes", acc_cnt - a0, 2);
        chk("t6_idle", busy, 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end
endmodule
